id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage directly downstream of the decode controller. Registers controller
//  control bundle plus decoded operands into EX; detects load-use hazards against the
//  instruction in EX, freezes PC and IF/ID, and injects a bubble. Honours a flush from
//  taken branch/jump resolution.
// PARAMETERS
//  DATA_W   32  register-file data / immediate / PC width
//  REG_AW    5  register index width
//  CNT_W    16  stall-counter width (only with IDEX_STALL_CNT_EN)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  id_regdst     in   2       controller RegDst
//  id_datawrite  in   2       controller DataWrite
//  id_regwrite   in   1       controller RegWrite
//  id_operation  in   3       controller ALU operation
//  id_alusrc     in   1       controller ALUsrc
//  id_memtoreg   in   1       controller MemtoReg
//  id_memwrite   in   1       controller MemWrite
//  id_memread    in   1       controller MemRead
//  id_rs/id_rt/id_rd in REG_AW  source/target/dest indices from IF/ID instruction
//  id_rdata1/2   in   DATA_W  register-file read data
//  id_imm        in   DATA_W  sign-extended immediate
//  id_pc4        in   DATA_W  PC+4 of decoding instruction
//  flush         in   1       kill instruction in ID (taken branch/jump)
//  ex_*          out  -       registered copies of every id_* above (same widths)
//  ex_valid      out  1       EX holds a real instruction (0 = bubble)
//  pc_write      out  1       0 freezes PC this cycle
//  ifid_write    out  1       0 freezes IF/ID this cycle
//  stall_cnt     out  CNT_W   load-use stall count (macro only)
// BEHAVIOUR
//  - Reset (async, immediate): all ex_* = 0, ex_valid=0, stall_cnt=0. Bubble == all-zero bundle.
//  - hazard (comb) = ex_memread & ex_valid & (ex_rt != 0) & (ex_rt==id_rs | ex_rt==id_rt).
//  - pc_write = ifid_write = ~hazard | flush (comb, no register). Reset: both 1 (hazard=0).
//  - Each posedge, priority flush > hazard > normal:
//      flush  : ex_* <= bubble, ex_valid<=0; PC/IF-ID not frozen (redirect proceeds).
//      hazard : ex_* <= bubble, ex_valid<=0; ID instruction held for retry.
//      normal : ex_* <= id_*, ex_valid<=1.
//  - Latency 1 cycle ID->EX. Load-use costs exactly one bubble: the bubble has
//    memread=0, so hazard self-clears next cycle; back-to-back lw->lw->use stalls once per pair.
//  - Register $0 never creates a hazard. Data fields (rdata, imm, pc4, rs/rt/rd) are also
//    zeroed in a bubble so EX-side compares never match stale indices.
//  - Reset deasserted mid-stall: first cycle after reset is normal (EX empty, no hazard).
//  - No handshake beyond stall/flush; stage always accepts when not stalled.
// CONFIGURATION
//  IDEX_STALL_CNT_EN defined: stall_cnt increments by 1 on each posedge where hazard & ~flush,
//    saturating at all-ones; cleared only by rst.
//  undefined: stall_cnt port tied to 0, counter logic absent.
// STRUCTURE
//  - Shared package pipeline_pkg: ctrl_bundle_t struct (regdst, datawrite, regwrite,
//    operation, alusrc, memtoreg, memwrite, memread), CTRL_BUBBLE constant (all zero),
//    opcode localparams (RT=0, ADDI=1, SLTI=2, LW=3, SW=4, BEQ=5, J=6, JR=7, JAL=8).
//  - Sub-module load_use_detector: pure comb, computes hazard from ex_memread/ex_valid/
//    ex_rt/id_rs/id_rt. Top holds the registers, priority mux and optional counter.
// TESTING
//  1 rst=1 with nonzero id_* -> all ex_*=0, ex_valid=0, pc_write=ifid_write=1.
//  2 add $3,$1,$2 decoded (regwrite=1,regdst=1) -> next edge ex_regwrite=1, ex_rd=3, ex_valid=1.
//  3 lw $5 in EX, ID rs=5 -> pc_write=0, ifid_write=0; next edge bubble; following edge ID forwarded, ex_valid=1.
//  4 lw $0 in EX, ID rs=0 -> no stall; ex_valid=1 next edge.
//  5 hazard and flush same cycle -> pc_write=1, bubble into EX, stall_cnt unchanged.
//  6 IDEX_STALL_CNT_EN, CNT_W=2, five load-use stalls -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: controller bundle, bubble constant and opcode encodings.
package pipeline_pkg;

  typedef struct packed {
    logic [1:0] regdst;
    logic [1:0] datawrite;
    logic       regwrite;
    logic [2:0] operation;
    logic       alusrc;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  localparam logic [3:0] RT   = 4'd0;
  localparam logic [3:0] ADDI = 4'd1;
  localparam logic [3:0] SLTI = 4'd2;
  localparam logic [3:0] LW   = 4'd3;
  localparam logic [3:0] SW   = 4'd4;
  localparam logic [3:0] BEQ  = 4'd5;
  localparam logic [3:0] J    = 4'd6;
  localparam logic [3:0] JR   = 4'd7;
  localparam logic [3:0] JAL  = 4'd8;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check: a valid load in EX whose target feeds the ID instruction.
module load_use_detector #(
  parameter int REG_AW = 5
) (
  input  logic              ex_memread,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hazard
);

  // $0 is hardwired to zero, so a load into it can never be a real dependency
  assign hazard = ex_memread & ex_valid & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble injection and flush.
// Optional load-use stall counter enabled by defining IDEX_STALL_CNT_EN.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        id_regdst,
  input  logic [1:0]        id_datawrite,
  input  logic              id_regwrite,
  input  logic [2:0]        id_operation,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_memwrite,
  input  logic              id_memread,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  output logic [1:0]        ex_regdst,
  output logic [1:0]        ex_datawrite,
  output logic              ex_regwrite,
  output logic [2:0]        ex_operation,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_memread,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_bundle_t id_ctrl, ex_ctrl;
  logic         hazard;
  logic         kill;

  assign id_ctrl = '{regdst: id_regdst, datawrite: id_datawrite, regwrite: id_regwrite,
                     operation: id_operation, alusrc: id_alusrc, memtoreg: id_memtoreg,
                     memwrite: id_memwrite, memread: id_memread};

  load_use_detector #(.REG_AW(REG_AW)) u_lud (
    .ex_memread (ex_ctrl.memread),
    .ex_valid   (ex_valid),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hazard     (hazard)
  );

  // a flush redirects the PC, so it overrides the freeze
  assign pc_write   = ~hazard | flush;
  assign ifid_write = ~hazard | flush;
  assign kill       = flush | hazard;

  // bubble zeroes data fields too, so stale indices never match downstream compares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl   <= CTRL_BUBBLE;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
      ex_valid  <= 1'b0;
    end else if (kill) begin
      ex_ctrl   <= CTRL_BUBBLE;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
      ex_valid  <= 1'b0;
    end else begin
      ex_ctrl   <= id_ctrl;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_pc4    <= id_pc4;
      ex_valid  <= 1'b1;
    end
  end

  assign ex_regdst    = ex_ctrl.regdst;
  assign ex_datawrite = ex_ctrl.datawrite;
  assign ex_regwrite  = ex_ctrl.regwrite;
  assign ex_operation = ex_ctrl.operation;
  assign ex_alusrc    = ex_ctrl.alusrc;
  assign ex_memtoreg  = ex_ctrl.memtoreg;
  assign ex_memwrite  = ex_ctrl.memwrite;
  assign ex_memread   = ex_ctrl.memread;

`ifdef IDEX_STALL_CNT_EN
  // counts only real stalls; a flushed hazard costs no extra cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (hazard && !flush && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases then randomized traffic vs a record-level model.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  typedef struct packed {
    logic [1:0]        regdst;
    logic [1:0]        datawrite;
    logic              regwrite;
    logic [2:0]        operation;
    logic              alusrc;
    logic              memtoreg;
    logic              memwrite;
    logic              memread;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  rec_t cur = '0;
  rec_t obs;
  logic ex_valid, pc_write, ifid_write;
  logic [CNT_W-1:0] stall_cnt;

  // expected state
  rec_t m = '0;
  logic m_valid = 1'b0;
  int   m_cnt = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_regdst(cur.regdst), .id_datawrite(cur.datawrite), .id_regwrite(cur.regwrite),
    .id_operation(cur.operation), .id_alusrc(cur.alusrc), .id_memtoreg(cur.memtoreg),
    .id_memwrite(cur.memwrite), .id_memread(cur.memread),
    .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
    .id_rdata1(cur.rdata1), .id_rdata2(cur.rdata2), .id_imm(cur.imm), .id_pc4(cur.pc4),
    .flush(flush),
    .ex_regdst(obs.regdst), .ex_datawrite(obs.datawrite), .ex_regwrite(obs.regwrite),
    .ex_operation(obs.operation), .ex_alusrc(obs.alusrc), .ex_memtoreg(obs.memtoreg),
    .ex_memwrite(obs.memwrite), .ex_memread(obs.memread),
    .ex_rs(obs.rs), .ex_rt(obs.rt), .ex_rd(obs.rd),
    .ex_rdata1(obs.rdata1), .ex_rdata2(obs.rdata2), .ex_imm(obs.imm), .ex_pc4(obs.pc4),
    .ex_valid(ex_valid), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // a load in EX stalls the ID instruction when it reads the loaded (nonzero) register
  function automatic logic model_hazard();
    return m_valid && m.memread && (m.rt != 0) && (m.rt == cur.rs || m.rt == cur.rt);
  endfunction

  function automatic int exp_cnt();
`ifdef IDEX_STALL_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // check comb outputs, clock once, advance model, check registered outputs
  task automatic step();
    logic haz;
    haz = model_hazard();
    #1;
    chk("pc_write", 256'(pc_write), 256'(!haz || flush));
    chk("ifid_write", 256'(ifid_write), 256'(!haz || flush));
    @(posedge clk);
    if (flush || haz) begin
      m = '0;
      m_valid = 1'b0;
      if (haz && !flush && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else begin
      m = cur;
      m_valid = 1'b1;
    end
    #1;
    chk("ex_bundle", 256'(obs), 256'(m));
    chk("ex_valid", 256'(ex_valid), 256'(m_valid));
    chk("stall_cnt", 256'(stall_cnt), 256'(exp_cnt()));
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r = rec_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    r.memread = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 1) == 1) r.rs = m.rt;
    if ($urandom_range(0, 3) == 0) r.rt = m.rt;
    if ($urandom_range(0, 5) == 0) r.rt = '0;
    return r;
  endfunction

  initial begin
    // reset with nonzero inputs
    cur = rec_t'({5{32'hA5A5_5A5A}});
    flush = 1'b0;
    #12;
    chk("rst_bundle", 256'(obs), 256'(0));
    chk("rst_valid", 256'(ex_valid), 256'(0));
    chk("rst_pc_write", 256'(pc_write), 256'(1));
    chk("rst_ifid_write", 256'(ifid_write), 256'(1));
    chk("rst_cnt", 256'(stall_cnt), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    cur = '0;

    // add $3,$1,$2
    cur.regwrite = 1'b1; cur.regdst = 2'd1; cur.rs = 5'd1; cur.rt = 5'd2; cur.rd = 5'd3;
    cur.rdata1 = 32'd11; cur.rdata2 = 32'd22; cur.pc4 = 32'h104;
    step();
    chk("add_rd", 256'(obs.rd), 256'(3));
    chk("add_regwrite", 256'(obs.regwrite), 256'(1));

    // lw $5 then a use of $5: one bubble, then forwarded
    cur = '0; cur.memread = 1'b1; cur.memtoreg = 1'b1; cur.alusrc = 1'b1; cur.regwrite = 1'b1;
    cur.rs = 5'd1; cur.rt = 5'd5; cur.imm = 32'd8; cur.pc4 = 32'h108;
    step();
    cur = '0; cur.regwrite = 1'b1; cur.regdst = 2'd1; cur.rs = 5'd5; cur.rt = 5'd6; cur.rd = 5'd7;
    cur.pc4 = 32'h10C;
    #1;
    chk("lu_pc_write", 256'(pc_write), 256'(0));
    chk("lu_ifid_write", 256'(ifid_write), 256'(0));
    step();
    chk("lu_bubble", 256'(ex_valid), 256'(0));
    step();
    chk("lu_retry", 256'(ex_valid), 256'(1));
    chk("lu_retry_rs", 256'(obs.rs), 256'(5));

    // lw $0 never stalls
    cur = '0; cur.memread = 1'b1; cur.rt = 5'd0; cur.pc4 = 32'h110;
    step();
    cur = '0; cur.rs = 5'd0; cur.rt = 5'd0; cur.rd = 5'd4; cur.pc4 = 32'h114;
    step();
    chk("lw0_valid", 256'(ex_valid), 256'(1));

    // hazard and flush together
    cur = '0; cur.memread = 1'b1; cur.rt = 5'd7; cur.pc4 = 32'h118;
    step();
    cur = '0; cur.rs = 5'd7; cur.rd = 5'd8; cur.pc4 = 32'h11C;
    flush = 1'b1;
    step();
    chk("hf_bubble", 256'(ex_valid), 256'(0));
    flush = 1'b0;

    // async reset asserted mid-stall, then normal first cycle
    cur = '0; cur.memread = 1'b1; cur.rt = 5'd9;
    step();
    cur = '0; cur.rt = 5'd9; cur.rd = 5'd10; cur.imm = 32'h55;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 256'(ex_valid), 256'(0));
    chk("async_rst_bundle", 256'(obs), 256'(0));
    m = '0; m_valid = 1'b0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_valid", 256'(ex_valid), 256'(1));

    // repeated load-use pairs (counter saturates when enabled)
    for (int i = 0; i < 5; i++) begin
      cur = '0; cur.memread = 1'b1; cur.rt = 5'd12;
      step();
      cur = '0; cur.rs = 5'd12;
      step();
      step();
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cur = rand_rec();
      flush = ($urandom_range(0, 7) == 0);
      step();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
